// File: rtl/yuv444to422_pack_pkg.sv
// Pixel formats and packing helpers shared by the 4:4:4 -> 4:2:2 packer.
// Chroma averaging (YUV444TO422_AVG_EN) is selected in yuv_pair_pack, not here.
package yuv_pkg;

    localparam int PIX_PER_BEAT_444 = 2;
    localparam int PIX_PER_BEAT_422 = 4;

    typedef struct packed {
        logic [7:0] pad;
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } pixel444_t;

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] y1;
        logic [7:0] u;
        logic [7:0] y0;
    } pixel422_pair_t;

    // Round-half-up mean; the 9-bit sum cannot overflow, the result always fits 8 bits.
    function automatic logic [7:0] chroma_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    // Decimating pack: chroma comes from the even pixel only.
    function automatic pixel422_pair_t pack_pair(input pixel444_t p0, input pixel444_t p1);
        pixel422_pair_t r;
        r.y0 = p0.y;
        r.u  = p0.u;
        r.y1 = p1.y;
        r.v  = p0.v;
        return r;
    endfunction

endpackage

// File: rtl/yuv444to422_pack_if.sv
// AXI-stream style channel used on both sides of the packer.
interface nasti_stream_channel #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    logic                      t_valid;
    logic                      t_ready;
    logic [DATA_WIDTH-1:0]     t_data;
    logic [DATA_WIDTH/8-1:0]   t_keep;
    logic [DATA_WIDTH/8-1:0]   t_strb;
    logic                      t_last;
    logic [ID_WIDTH-1:0]       t_id;
    logic [DEST_WIDTH-1:0]     t_dest;
    logic [USER_WIDTH-1:0]     t_user;

    modport master (
        output t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/yuv444to422_pack_yuv_pair_pack.sv
// Combinational conversion of two 4:4:4 pixels into one Y0/U/Y1/V group.
// Define YUV444TO422_AVG_EN to average the chroma of both pixels instead of decimating.
module yuv_pair_pack
    import yuv_pkg::*;
(
    input  pixel444_t      i_p0,
    input  pixel444_t      i_p1,
    output pixel422_pair_t o_pair
);

    pixel422_pair_t w_base;
    logic           w_unused;

    assign w_base = pack_pair(i_p0, i_p1);

`ifdef YUV444TO422_AVG_EN
    assign o_pair = '{
        v:  chroma_avg(i_p0.v, i_p1.v),
        y1: w_base.y1,
        u:  chroma_avg(i_p0.u, i_p1.u),
        y0: w_base.y0
    };
    assign w_unused = ^{i_p0.pad, i_p1.pad};
`else
    assign o_pair   = w_base;
    assign w_unused = ^{i_p0.pad, i_p1.pad, i_p1.u, i_p1.v};
`endif

endmodule

// File: rtl/yuv444to422_pack.sv
// Packs a 2 pixel/beat 4:4:4 stream into a 4 pixel/beat 4:2:2 stream, one output per input pair.
// Chroma mode is chosen by the YUV444TO422_AVG_EN macro (average when defined, decimate otherwise).
module yuv444to422_pack
    import yuv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    nasti_stream_channel.slave  src,
    nasti_stream_channel.master dst
);

    localparam int NUM_GROUPS = PIX_PER_BEAT_422 / 2;

    generate
        if (DATA_WIDTH != 64) begin : g_bad_width
            $error("yuv444to422_pack supports DATA_WIDTH=64 only");
        end
    endgenerate

    logic                  r_half;
    logic [63:0]           r_hold;
    logic                  r_out_valid;
    logic [63:0]           r_out_data;
    logic [7:0]            r_out_keep;
    logic                  r_out_last;
    logic [DEST_WIDTH-1:0] r_out_dest;

    logic                  w_src_ready;
    logic                  w_accept;
    logic [63:0]           w_grp_src [NUM_GROUPS];
    pixel422_pair_t        w_grp     [NUM_GROUPS];
    logic                  w_unused;

    assign w_src_ready = !r_out_valid || dst.t_ready;
    assign w_accept    = src.t_valid && w_src_ready;

    // Group 0 normally comes from the held first beat; for a lone odd beat it is the live beat.
    assign w_grp_src[0] = r_half ? r_hold : src.t_data;
    assign w_grp_src[1] = src.t_data;

    generate
        for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_pack
            yuv_pair_pack u_pair_pack (
                .i_p0   (w_grp_src[gi][31:0]),
                .i_p1   (w_grp_src[gi][63:32]),
                .o_pair (w_grp[gi])
            );
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_half      <= 1'b0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_dest  <= '0;
        end else begin
            if (w_accept && r_half) begin
                r_out_data  <= {w_grp[1], w_grp[0]};
                r_out_keep  <= 8'hFF;
                r_out_last  <= src.t_last;
                r_out_dest  <= src.t_dest;
                r_out_valid <= 1'b1;
                r_half      <= 1'b0;
            end else if (w_accept && src.t_last) begin
                r_out_data  <= {32'h0, w_grp[0]};
                r_out_keep  <= 8'h0F;
                r_out_last  <= 1'b1;
                r_out_dest  <= src.t_dest;
                r_out_valid <= 1'b1;
            end else begin
                if (w_accept) begin
                    r_hold <= src.t_data;
                    r_half <= 1'b1;
                end
                if (dst.t_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign src.t_ready = w_src_ready;

    assign dst.t_valid = r_out_valid;
    assign dst.t_data  = r_out_data;
    assign dst.t_keep  = r_out_keep;
    assign dst.t_strb  = r_out_keep;
    assign dst.t_last  = r_out_last;
    assign dst.t_dest  = r_out_dest;
    assign dst.t_id    = '0;
    assign dst.t_user  = '0;

    // Input keep/strb/id/user carry no information for this packer.
    assign w_unused = ^{src.t_keep, src.t_strb, src.t_id, src.t_user};

endmodule

// File: tb/tb_yuv444to422_pack.sv
// Self-checking bench for yuv444to422_pack: directed cases plus randomized traffic
// against a pixel-arithmetic reference model.
module tb_yuv444to422_pack;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    nasti_stream_channel #(.DATA_WIDTH(64), .DEST_WIDTH(1)) src_if ();
    nasti_stream_channel #(.DATA_WIDTH(64), .DEST_WIDTH(1)) dst_if ();

    yuv444to422_pack #(.DATA_WIDTH(64), .DEST_WIDTH(1)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .src     (src_if),
        .dst     (dst_if)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        dest;
    } beat_t;

    localparam logic [63:0] BEAT_B = 64'h004080C0_00102030;
    localparam logic [63:0] RND_0  = 64'h0011FE01_0022FF00;
    localparam logic [63:0] RND_1  = 64'h004401FF_003300FF;
`ifdef YUV444TO422_AVG_EN
    localparam logic [63:0] EXP_PAIR = 64'h78405010_78405010;
    localparam logic [63:0] EXP_ODD  = 64'h00000000_78405010;
    localparam logic [63:0] EXP_RND  = 64'hFF440133_0111FF22;
`else
    localparam logic [63:0] EXP_PAIR = 64'h30402010_30402010;
    localparam logic [63:0] EXP_ODD  = 64'h00000000_30402010;
    localparam logic [63:0] EXP_RND  = 64'hFF440033_0011FF22;
`endif

    int          total;
    int          bad;
    int          cyc;
    int          out_cnt;
    logic        src_rdy_s;
    logic [63:0] last_out;
    logic [7:0]  last_keep;
    logic        last_last;
    beat_t       exp_q[$];
    logic        m_half;
    logic [63:0] m_first;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One 4:2:2 group from a 4:4:4 beat, using plain integer pixel arithmetic.
    function automatic logic [31:0] ref_group(input logic [63:0] beat);
        longint unsigned b, p0, p1, y0, u0, v0, y1, u1, v1, u, v;
        b  = beat;
        p0 = b % (64'd1 << 32);
        p1 = b >> 32;
        v0 = p0 % 256;  u0 = (p0 / 256) % 256;  y0 = (p0 / 65536) % 256;
        v1 = p1 % 256;  u1 = (p1 / 256) % 256;  y1 = (p1 / 65536) % 256;
`ifdef YUV444TO422_AVG_EN
        u = (u0 + u1 + 1) / 2;
        v = (v0 + v1 + 1) / 2;
`else
        u = u0 + 0 * u1;
        v = v0 + 0 * v1;
`endif
        return 32'(v * (64'd1 << 24) + y1 * 65536 + u * 256 + y0);
    endfunction

    task automatic model_accept(input logic [63:0] d, input logic l, input logic de);
        beat_t e;
        if (!m_half) begin
            if (l) begin
                e.data = {32'h0, ref_group(d)};
                e.keep = 8'h0F; e.last = 1'b1; e.dest = de;
                exp_q.push_back(e);
            end else begin
                m_first = d;
                m_half  = 1'b1;
            end
        end else begin
            e.data = {ref_group(d), ref_group(m_first)};
            e.keep = 8'hFF; e.last = l; e.dest = de;
            exp_q.push_back(e);
            m_half = 1'b0;
        end
    endtask

    // Drive on the falling edge, then observe the handshakes the next rising edge will complete.
    task automatic cycle(input logic v, input logic [63:0] d, input logic l, input logic de,
                         input logic rdy, output logic acc);
        beat_t e;
        @(negedge aclk);
        src_if.t_valid = v;
        src_if.t_data  = d;
        src_if.t_last  = l;
        src_if.t_dest  = de;
        dst_if.t_ready = rdy;
        #1;
        cyc++;
        src_rdy_s = src_if.t_ready;
        acc = v && src_if.t_ready;
        if (dst_if.t_valid && rdy) begin
            out_cnt++;
            last_out  = dst_if.t_data;
            last_keep = dst_if.t_keep;
            last_last = dst_if.t_last;
            $display("out %0d: data=%h keep=%h last=%0b dest=%0b", out_cnt, dst_if.t_data,
                     dst_if.t_keep, dst_if.t_last, dst_if.t_dest);
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", dst_if.t_data, e.data);
                chk("out_keep", 64'(dst_if.t_keep), 64'(e.keep));
                chk("out_strb", 64'(dst_if.t_strb), 64'(e.keep));
                chk("out_last", 64'(dst_if.t_last), 64'(e.last));
                chk("out_dest", 64'(dst_if.t_dest), 64'(e.dest));
            end
        end
        if (acc) model_accept(d, l, de);
    endtask

    task automatic send(input logic [63:0] d, input logic l, input logic de, input bit rnd);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            if (rnd) cycle(($urandom_range(0, 3) != 0), d, l, de, ($urandom_range(0, 2) != 0), acc);
            else     cycle(1'b1, d, l, de, 1'b1, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          o0, bi, bp_acc, rdy_bad, stable_bad, stalls, acc2_cyc, fv_cyc;
        logic        have_ref;
        logic [63:0] ref_data;
        logic [63:0] bp_data [4];

        total = 0; bad = 0; cyc = 0; out_cnt = 0; m_half = 1'b0; m_first = '0;
        src_if.t_valid = 1'b0; src_if.t_data = '0; src_if.t_keep = 8'hFF; src_if.t_strb = 8'hFF;
        src_if.t_last = 1'b0; src_if.t_dest = 1'b0; src_if.t_id = '0; src_if.t_user = '0;
        dst_if.t_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", 64'(dst_if.t_valid), 64'd0);
        chk("rst_data",  dst_if.t_data, 64'd0);
        chk("rst_keep",  64'(dst_if.t_keep), 64'd0);
        chk("rst_strb",  64'(dst_if.t_strb), 64'd0);
        chk("rst_last",  64'(dst_if.t_last), 64'd0);
        chk("rst_dest",  64'(dst_if.t_dest), 64'd0);
        chk("rst_src_ready", 64'(src_if.t_ready), 64'd1);
        @(negedge aclk);
        aresetn = 1'b1;

        // Basic pair
        send(BEAT_B, 1'b0, 1'b1, 1'b0);
        send(BEAT_B, 1'b1, 1'b1, 1'b0);
        drain();
        chk("pair_data", last_out, EXP_PAIR);
        chk("pair_keep", 64'(last_keep), 64'hFF);
        chk("pair_last", 64'(last_last), 64'd1);

        // Odd packet, then a normal pair restarting from an empty hold
        send(BEAT_B, 1'b1, 1'b0, 1'b0);
        drain();
        chk("odd_data", last_out, EXP_ODD);
        chk("odd_keep", 64'(last_keep), 64'h0F);
        chk("odd_last", 64'(last_last), 64'd1);
        send(BEAT_B, 1'b0, 1'b0, 1'b0);
        send(BEAT_B, 1'b1, 1'b0, 1'b0);
        drain();
        chk("after_odd_data", last_out, EXP_PAIR);

        // Chroma rounding corner cases
        send(RND_0, 1'b0, 1'b0, 1'b0);
        send(RND_1, 1'b1, 1'b0, 1'b0);
        drain();
        chk("round_data", last_out, EXP_RND);

        // Backpressure: 10 stalled cycles while 4 beats are offered
        for (int i = 0; i < 4; i++) bp_data[i] = {$urandom, $urandom};
        o0 = out_cnt; bi = 0; bp_acc = 0; rdy_bad = 0; stable_bad = 0; have_ref = 1'b0; ref_data = '0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, bp_data[bi], (bi == 3), 1'b0, 1'b0, acc);
            if (bp_acc >= 2 && src_rdy_s) rdy_bad++;
            if (acc) begin bi++; bp_acc++; end
            if (dst_if.t_valid) begin
                if (!have_ref) begin ref_data = dst_if.t_data; have_ref = 1'b1; end
                else if (dst_if.t_data !== ref_data) stable_bad++;
            end
        end
        chk("bp_accepts", 64'(bp_acc), 64'd2);
        chk("bp_src_ready_low", 64'(rdy_bad), 64'd0);
        chk("bp_out_valid", 64'(dst_if.t_valid), 64'd1);
        chk("bp_out_stable", 64'(stable_bad), 64'd0);
        while (bi < 4) begin
            send(bp_data[bi], (bi == 3), 1'b0, 1'b0);
            bi++;
        end
        drain();
        chk("bp_outputs", 64'(out_cnt - o0), 64'd2);

        // Throughput and latency: 32 back-to-back beats
        o0 = out_cnt; stalls = 0; acc2_cyc = -100; fv_cyc = -1;
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, {$urandom, $urandom}, (i == 31), 1'($urandom), 1'b1, acc);
            if (!acc) stalls++;
            if (i == 1) acc2_cyc = cyc;
            if (dst_if.t_valid && fv_cyc < 0) fv_cyc = cyc;
        end
        drain();
        chk("tp_stalls", 64'(stalls), 64'd0);
        chk("tp_outputs", 64'(out_cnt - o0), 64'd16);
        chk("tp_latency", 64'(fv_cyc - acc2_cyc), 64'd1);

        // Reset mid-pair: output must clear without waiting for a clock edge
        send({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        src_if.t_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        m_half = 1'b0;
        exp_q.delete();
        chk("midrst_valid", 64'(dst_if.t_valid), 64'd0);
        chk("midrst_data",  dst_if.t_data, 64'd0);
        chk("midrst_keep",  64'(dst_if.t_keep), 64'd0);
        chk("midrst_last",  64'(dst_if.t_last), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        send(BEAT_B, 1'b0, 1'b0, 1'b0);
        send(BEAT_B, 1'b1, 1'b0, 1'b0);
        drain();
        chk("midrst_pair", last_out, EXP_PAIR);

        // Randomized traffic with random valid/ready, packet lengths and keep bits
        for (int i = 0; i < 300; i++) begin
            src_if.t_keep = 8'($urandom);
            src_if.t_strb = 8'($urandom);
            send({$urandom, $urandom}, ($urandom_range(0, 4) == 0), 1'($urandom), 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/yuv444to422_pack.md
Name: yuv444to422_pack

Overview:
- Inverse of the 4:2:2 to 4:4:4 chroma expander.
- Consumes a 64-bit 4:4:4 pixel stream of 2 pixels/beat and emits a packed 64-bit 4:2:2 stream of 4 pixels/beat.
- Sits between the processing pipeline's nasti_stream_channel output and a stream_nasti_mover that writes frames back to memory.
- Two input beats produce one output beat, at full input rate.

Parameters:
DATA_WIDTH, 64, stream data width; only 64 is supported (elaboration $error otherwise)
DEST_WIDTH, 1, width of t_dest, passed through from the second input beat of each pair

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
src  nasti_stream_channel slave  DATA_WIDTH  4:4:4 input; uses t_valid, t_ready, t_data, t_keep, t_strb, t_last, t_dest
dst  nasti_stream_channel master  DATA_WIDTH  4:2:2 output; drives t_valid, t_data, t_keep, t_strb, t_last, t_dest, t_id=0, t_user=0

Behaviour:
- Input pixel k (k=0,1) in bits [32k+31:32k]:
  - [7:0]=V, [15:8]=U, [23:16]=Y, [31:24]=pad (ignored).
- Output group j (j=0,1) in bits [32j+31:32j]:
  - [7:0]=Y0, [15:8]=U, [23:16]=Y1, [31:24]=V.
- Group j is built from the two pixels of input beat j of the pair (beat 0 = first accepted).
- State: half flag (0 = no pixels held, 1 = first beat held), hold register (64b), output register, out_valid.
- src.t_ready = !out_valid || dst.t_ready. A beat is accepted on src.t_valid && src.t_ready.
- Accept with half=0:
  - Store data in hold, set half=1.
  - If t_last=1 (odd-length packet), instead emit immediately:
    - group0 from this beat, group1=0, t_keep=t_strb=8'h0F, t_last=1; half stays 0.
- Accept with half=1:
  - Load output register: group0 from hold, group1 from the current beat.
  - t_keep=t_strb=8'hFF, t_last=src.t_last, t_dest=src.t_dest.
  - Set out_valid=1, half=0.
- Output register is cleared (out_valid=0) on dst.t_valid && dst.t_ready unless reloaded in the same cycle. A simultaneous drain and load keeps out_valid=1 with the new data.
- Latency: output valid the cycle after the second input beat is accepted. Sustained rate is 1 output beat per 2 input cycles with no bubbles.
- Backpressure: while out_valid && !dst.t_ready, src.t_ready=0; the hold register keeps its value.
- Incoming t_keep/t_strb bits other than all-ones or 8'h00 are ignored; all-zero beats are treated as data.
- Reset (aresetn low, any time, including mid-pair): half=0, out_valid=0, dst.t_valid=0, dst.t_data=0, dst.t_keep=0, dst.t_strb=0, dst.t_last=0, dst.t_dest=0. A partially held pair is discarded.
- Chroma: U/V per group per the optional feature.

Optional Feature:
- Macro YUV444TO422_AVG_EN.
- Defined: U=(U0+U1+1)>>1 and V=(V0+V1+1)>>1, with a 9-bit intermediate and round-half-up. Result always fits in 8 bits.
- Undefined: decimate, U=U0 and V=V0 from the even pixel; the odd pixel's chroma is dropped.
- Latency is unchanged in both builds.

Decomposition:
- Package yuv_pkg holds:
  - pixel444_t struct {pad, Y, U, V}
  - pixel422_pair_t struct {V, Y1, U, Y0}
  - localparam PIX_PER_BEAT_444=2, PIX_PER_BEAT_422=4
  - function pack_pair(pixel444_t p0, p1) returning pixel422_pair_t
- One combinational sub-module, yuv_pair_pack, converts two pixel444_t into one pixel422_pair_t and contains the YUV444TO422_AVG_EN switch. It is instantiated twice, once per output group.

Test Plan:
- Basic pair:
  - Stimulus: beats 64'h004080C0_00102030 twice, t_last on the second, dst.t_ready=1.
  - AVG_EN build -> one beat 64'h78405010_78405010, keep FF, last=1.
  - Non-AVG build -> 64'h30402010_30402010.
- Odd packet: single beat 64'h004080C0_00102030 with t_last=1 -> dst 64'h00000000_30402010 (non-AVG), keep 8'h0F, last=1, next packet restarts at half=0.
- Backpressure:
  - Stimulus: dst.t_ready=0 for 10 cycles while 4 beats are offered.
  - Required: src.t_ready drops after the 2nd accepted beat and the output holds stable. After release, 2 outputs in order with no loss or duplication.
- Throughput: 32 back-to-back beats with dst.t_ready=1 -> 16 output beats, src.t_ready never deasserts, first output 1 cycle after the 2nd accept.
- Reset mid-pair: accept 1 beat, pulse aresetn low -> all dst outputs 0 asynchronously. The next two beats form a clean pair with no stale hold data.
- Rounding (AVG_EN): U0=0xFF, U1=0xFE -> U=0xFF; U0=0x00, U1=0x01 -> U=0x01; U0=U1=0xFF -> 0xFF (no overflow).
